// File: rtl/div_seq.sv
// Multi-cycle 32-bit restoring divider for the EX stage (DIV/DIVU).
// Returns {remainder, quotient} and requests a pipeline stall while busy.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        annul_i,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    // state     | meaning
    // ST_FREE   | idle, waiting for start_i
    // ST_BYZERO | divisor was zero, result forced to 0
    // ST_ON     | one shift-subtract iteration per clock
    // ST_END    | result valid, held until start_i drops
    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t      state, state_nx;
    logic [31:0] quo_r, div_r, rem_r;
    logic [5:0]  cnt;
    logic        neg_q, neg_r;

    logic        load_ops, step, load_res, clr_res;
    logic [32:0] shifted_r, diff;
    logic        ge;
    logic [31:0] rem_nx, quo_nx, rem_fin, quo_fin;

    // Partial remainder carries a 33rd bit so divisors above 2^31 still compare correctly.
    assign shifted_r = {rem_r, quo_r[31]};
    assign diff      = shifted_r - {1'b0, div_r};
    assign ge        = ~diff[32];
    assign rem_nx    = ge ? diff[31:0] : shifted_r[31:0];
    assign quo_nx    = {quo_r[30:0], ge};
    assign quo_fin   = neg_q ? -quo_nx : quo_nx;
    assign rem_fin   = neg_r ? -rem_nx : rem_nx;

    assign ready_o   = (state == ST_END);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FREE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        load_ops   = 1'b0;
        step       = 1'b0;
        load_res   = 1'b0;
        clr_res    = 1'b0;
        stallreq_o = 1'b0;
        case (state)
            ST_FREE: begin
                if (start_i && !annul_i) begin
                    stallreq_o = 1'b1;
                    if (opdata2_i == 32'd0) begin
                        state_nx = ST_BYZERO;
                    end else begin
                        state_nx = ST_ON;
                        load_ops = 1'b1;
                    end
                end
            end
            ST_BYZERO: begin
                clr_res = 1'b1;
                if (annul_i) begin
                    state_nx = ST_FREE;
                end else begin
                    stallreq_o = 1'b1;
                    state_nx   = ST_END;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_nx = ST_FREE;
                    clr_res  = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                    step       = 1'b1;
                    if (cnt == 6'd31) begin
                        state_nx = ST_END;
                        load_res = 1'b1;
                    end
                end
            end
            ST_END: begin
                if (annul_i || !start_i) begin
                    state_nx = ST_FREE;
                    clr_res  = 1'b1;
                end
            end
            default: begin
                state_nx = ST_FREE;
                clr_res  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quo_r    <= 32'd0;
            div_r    <= 32'd0;
            rem_r    <= 32'd0;
            cnt      <= 6'd0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= 64'd0;
        end else begin
            if (load_ops) begin
                quo_r <= (signed_div_i && opdata1_i[31]) ? -opdata1_i : opdata1_i;
                div_r <= (signed_div_i && opdata2_i[31]) ? -opdata2_i : opdata2_i;
                rem_r <= 32'd0;
                cnt   <= 6'd0;
                neg_q <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                neg_r <= signed_div_i & opdata1_i[31];
            end else if (step) begin
                quo_r <= quo_nx;
                rem_r <= rem_nx;
                cnt   <= cnt + 6'd1;
            end

            if (load_res) begin
                result_o <= {rem_fin, quo_fin};
            end else if (clr_res) begin
                result_o <= 64'd0;
            end
        end
    end

endmodule
